// File: rtl/cmd_queue_if.sv
// -----------------------------------------------------------------------------
// cmd_queue_if
// Handshake bundle for cmd_queue: per-source command strobes on the input
// side, and the FIFO head valid/ready pair on the output side.
//   src_valid  NSRC        one-cycle command strobe per source
//   src_cmd    NSRC*CMD_W  command code per source, source i at [i*CMD_W +: CMD_W]
//   out_valid  1           FIFO head valid
//   out_cmd    CMD_W       FIFO head code
//   out_ready  1           consumer takes the head this cycle
// master = command producers / consumer side, slave = the queue itself.
// -----------------------------------------------------------------------------
interface cmd_queue_if #(
    parameter int NSRC  = 4,
    parameter int CMD_W = 4
);
    logic [NSRC-1:0]       src_valid;
    logic [NSRC*CMD_W-1:0] src_cmd;
    logic                  out_valid;
    logic [CMD_W-1:0]      out_cmd;
    logic                  out_ready;

    modport master (
        output src_valid,
        output src_cmd,
        output out_ready,
        input  out_valid,
        input  out_cmd
    );

    modport slave (
        input  src_valid,
        input  src_cmd,
        input  out_ready,
        output out_valid,
        output out_cmd
    );
endinterface

// File: rtl/cmd_queue.sv
// -----------------------------------------------------------------------------
// cmd_queue
// Game command queue: NSRC prioritised command sources (index 0 highest) plus
// a lowest-priority gravity timer feed a DEPTH-entry FIFO. At most one command
// is enqueued per cycle; lost commands bump a saturating drop counter.
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   enable       game running; low flushes the queue and gravity state
//   bus          cmd_queue_if.slave (src_valid/src_cmd in, out_valid/out_cmd/
//                out_ready FIFO head handshake)
//   grav_period  clocks per automatic command, 0 disables gravity
//   grav_cmd     code injected by the gravity timer
//   count        current FIFO occupancy
//   drop_cnt     saturating count of cycles in which a command was lost
// -----------------------------------------------------------------------------
module cmd_queue #(
    parameter int NSRC   = 4,
    parameter int DEPTH  = 16,
    parameter int CMD_W  = 4,
    parameter int TICK_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    cmd_queue_if.slave               bus,
    input  logic [TICK_W-1:0]        grav_period,
    input  logic [CMD_W-1:0]         grav_cmd,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage: plain array, written only on push, read through out_cmd_reg.
    logic [CMD_W-1:0]  mem [DEPTH];

    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CMD_W-1:0]  out_cmd_reg;
    logic [TICK_W-1:0] grav_cnt_reg;
    logic              grav_pend_reg;
    logic [7:0]        drop_cnt_reg;

    // Per-source request: strobe with a non-NONE code.
    logic [NSRC-1:0]   req;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_req
            assign req[gi] = bus.src_valid[gi] &&
                             (bus.src_cmd[gi*CMD_W +: CMD_W] != '0);
        end
    endgenerate

    // Lowest index wins: scan from the top so the last hit is the winner.
    logic             win_valid;
    logic [CMD_W-1:0] win_cmd;

    always_comb begin
        win_valid = 1'b0;
        win_cmd   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_cmd   = bus.src_cmd[i*CMD_W +: CMD_W];
            end
        end
    end

    // More than one request bit set means at least one loser this cycle.
    logic multi_req;
    assign multi_req = |(req & (req - NSRC'(1)));

    logic             pop;
    logic             space;
    logic             grav_expire;
    logic             grav_avail;
    logic             win_grav;
    logic             push;
    logic             grav_push;
    logic             drop_event;
    logic [CMD_W-1:0] push_cmd;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_next;

    assign pop   = (count_reg != '0) && bus.out_ready;
    // A full queue still accepts a push when the head leaves the same cycle.
    assign space = (count_reg != CW'(DEPTH)) || pop;

    // ">=" rather than "==" so a shortened period takes effect at once.
    assign grav_expire = (grav_period != '0) &&
                         (grav_cnt_reg >= grav_period - TICK_W'(1));
    // An expiry can be served in the very cycle it happens.
    assign grav_avail  = grav_pend_reg || grav_expire;
    // A player command equal to the gravity code satisfies the gravity tick.
    assign win_grav    = win_valid && (win_cmd == grav_cmd);

    assign push_cmd   = win_valid ? win_cmd : grav_cmd;
    assign push       = (win_valid || grav_avail) && space;
    assign grav_push  = !win_valid && grav_avail && space;
    // Losers and a full-queue discard in the same cycle count only once.
    assign drop_event = multi_req || (win_valid && !space);

    assign rd_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enable && push) begin
            mem[wr_ptr_reg] <= push_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            out_cmd_reg   <= '0;
            grav_cnt_reg  <= '0;
            grav_pend_reg <= 1'b0;
            drop_cnt_reg  <= '0;
        end else if (!enable) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            out_cmd_reg   <= '0;
            grav_cnt_reg  <= '0;
            grav_pend_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_next;
            count_reg  <= count_next;

            // Next head is the entry being written now only when the queue
            // drains to (or starts from) empty; otherwise it is in storage.
            if (push && (rd_next == wr_ptr_reg)) begin
                out_cmd_reg <= push_cmd;
            end else begin
                out_cmd_reg <= mem[rd_next];
            end

            if (win_grav) begin
                grav_cnt_reg <= '0;
            end else if (grav_period != '0) begin
                grav_cnt_reg <= grav_expire ? '0 : grav_cnt_reg + TICK_W'(1);
            end

            // Pending gravity survives until it is enqueued or superseded.
            grav_pend_reg <= win_grav ? 1'b0 : (grav_avail && !grav_push);

            if (drop_event && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.out_valid = (count_reg != '0);
    assign bus.out_cmd   = out_cmd_reg;
    assign count         = count_reg;
    assign drop_cnt      = drop_cnt_reg;
endmodule
